// File: rtl/sdfa_neuron_array_if.sv
`default_nettype none
// ============================================================================
// Module   : sdfa_neuron_array_if
// Brief    : Block-level bus for sdfa_neuron_array: control, spike/weight
//            stream in, per-lane sums and fire results out.
// Revision : 1.0
// ============================================================================
interface sdfa_neuron_array_if #(
    parameter int N_NEURON  = 8,
    parameter int W_WIDTH   = 9,
    parameter int ACC_WIDTH = 10
);
    logic                            new_block;
    logic                            cal_en;
    logic                            input_spike;
    logic                            read_done;
    logic                            fire_mode;
    logic [ACC_WIDTH-1:0]            threshold;
    logic [N_NEURON*W_WIDTH-1:0]     weight;
    logic                            cal_done;
    logic                            out_valid;
    logic [N_NEURON-1:0]             out_spike;
    logic [N_NEURON*ACC_WIDTH-1:0]   sum;

    modport master (
        output new_block, cal_en, input_spike, read_done, fire_mode, threshold, weight,
        input  cal_done, out_valid, out_spike, sum
    );

    modport slave (
        input  new_block, cal_en, input_spike, read_done, fire_mode, threshold, weight,
        output cal_done, out_valid, out_spike, sum
    );
endinterface
`default_nettype wire

// File: rtl/sdfa_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : sdfa_neuron_array
// Brief    : N lanes of saturating signed spike accumulators sharing one input
//            spike, with an optional one-cycle integrate-and-fire phase.
// Revision : 1.0
// ============================================================================
module sdfa_neuron_array #(
    parameter int N_NEURON   = 8,
    parameter int W_WIDTH    = 9,
    parameter int ACC_WIDTH  = 10,
    parameter int HARD_RESET = 0
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    sdfa_neuron_array_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_FIRE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ACC_WIDTH-1:0] C_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] C_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                               state_q;
    logic [N_NEURON-1:0][ACC_WIDTH-1:0]   sum_q;
    logic [N_NEURON-1:0]                  spike_q;
    logic                                 cal_done_q;
    logic                                 out_valid_q;

    logic [N_NEURON-1:0][ACC_WIDTH-1:0]   sum_add_d;
    logic [N_NEURON-1:0][ACC_WIDTH-1:0]   sum_fire_d;
    logic [N_NEURON-1:0]                  fire_d;

    // Operands are widened by one bit; a disagreement between the top two
    // result bits means overflow and the top bit tells which bound applies.
    function automatic logic [ACC_WIDTH-1:0] sat_fn(input logic [ACC_WIDTH:0] x);
        if (x[ACC_WIDTH] != x[ACC_WIDTH-1])
            return x[ACC_WIDTH] ? C_ACC_MIN : C_ACC_MAX;
        else
            return x[ACC_WIDTH-1:0];
    endfunction

    generate
        for (genvar g = 0; g < N_NEURON; g++) begin : g_lane
            logic [ACC_WIDTH-1:0] cur;
            logic [W_WIDTH-1:0]   w;
            logic [ACC_WIDTH:0]   add_ext;
            logic [ACC_WIDTH:0]   sub_ext;

            assign cur     = sum_q[g];
            assign w       = bus.weight[g*W_WIDTH +: W_WIDTH];
            assign add_ext = {cur[ACC_WIDTH-1], cur}
                           + {{(ACC_WIDTH+1-W_WIDTH){w[W_WIDTH-1]}}, w};
            assign sub_ext = {cur[ACC_WIDTH-1], cur}
                           - {bus.threshold[ACC_WIDTH-1], bus.threshold};

            assign sum_add_d[g] = sat_fn(add_ext);
            assign fire_d[g]    = $signed(cur) >= $signed(bus.threshold);

            if (HARD_RESET != 0) begin : g_hard
                assign sum_fire_d[g] = fire_d[g] ? '0 : cur;
            end else begin : g_soft
                assign sum_fire_d[g] = fire_d[g] ? sat_fn(sub_ext) : cur;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_ACC;
            sum_q       <= '0;
            spike_q     <= '0;
            cal_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.new_block) begin
            state_q     <= ST_ACC;
            sum_q       <= '0;
            spike_q     <= '0;
            cal_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_ACC: begin
                    if (bus.cal_en && bus.input_spike)
                        sum_q <= sum_add_d;
                    if (bus.read_done) begin
                        if (bus.fire_mode) begin
                            state_q <= ST_FIRE;
                        end else begin
                            state_q     <= ST_DONE;
                            spike_q     <= '0;
                            cal_done_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    sum_q       <= sum_fire_d;
                    spike_q     <= fire_d;
                    state_q     <= ST_DONE;
                    cal_done_q  <= 1'b1;
                    out_valid_q <= 1'b1;
                end
                default: begin
                    // DONE: results are frozen until the next block starts
                end
            endcase
        end
    end

    assign bus.sum       = sum_q;
    assign bus.out_spike = spike_q;
    assign bus.cal_done  = cal_done_q;
    assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sdfa_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdfa_neuron_array
// Brief    : Self-checking bench driving a soft-reset and a hard-reset array
//            with identical stimulus against a behavioural lane model.
// Revision : 1.0
// ============================================================================
module tb_sdfa_neuron_array;

    localparam int N  = 4;
    localparam int WW = 9;
    localparam int AW = 10;

    logic clk;
    logic rstn;
    logic new_block, cal_en, input_spike, read_done, fire_mode;
    logic [AW-1:0]   threshold;
    logic [N*WW-1:0] weight;

    sdfa_neuron_array_if #(.N_NEURON(N), .W_WIDTH(WW), .ACC_WIDTH(AW)) if_s ();
    sdfa_neuron_array_if #(.N_NEURON(N), .W_WIDTH(WW), .ACC_WIDTH(AW)) if_h ();

    assign if_s.new_block = new_block;   assign if_h.new_block = new_block;
    assign if_s.cal_en = cal_en;         assign if_h.cal_en = cal_en;
    assign if_s.input_spike = input_spike; assign if_h.input_spike = input_spike;
    assign if_s.read_done = read_done;   assign if_h.read_done = read_done;
    assign if_s.fire_mode = fire_mode;   assign if_h.fire_mode = fire_mode;
    assign if_s.threshold = threshold;   assign if_h.threshold = threshold;
    assign if_s.weight = weight;         assign if_h.weight = weight;

    sdfa_neuron_array #(.N_NEURON(N), .W_WIDTH(WW), .ACC_WIDTH(AW), .HARD_RESET(0))
        u_soft (.clk(clk), .rstn(rstn), .bus(if_s));
    sdfa_neuron_array #(.N_NEURON(N), .W_WIDTH(WW), .ACC_WIDTH(AW), .HARD_RESET(1))
        u_hard (.clk(clk), .rstn(rstn), .bus(if_h));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: index 0 = soft reset DUT, 1 = hard reset DUT
    int         m_sum [2][N];
    logic [N-1:0] m_spk [2];
    int         m_st;

    typedef struct packed {
        logic [N*AW-1:0] s_sum;
        logic [N*AW-1:0] h_sum;
        logic [N-1:0]    s_spk;
        logic [N-1:0]    h_spk;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    function automatic int sat(input int v);
        if (v > 511)  return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    function automatic int w_of(input int l);
        logic signed [WW-1:0] t;
        t = weight[l*WW +: WW];
        return int'(t);
    endfunction

    function automatic int lane_of(input logic [N*AW-1:0] v, input int l);
        logic signed [AW-1:0] t;
        t = v[l*AW +: AW];
        return int'(t);
    endfunction

    function automatic logic [N*AW-1:0] pack(input int d);
        logic [N*AW-1:0] r;
        int t;
        for (int l = 0; l < N; l++) begin
            t = m_sum[d][l];
            r[l*AW +: AW] = t[AW-1:0];
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < N; l++) m_sum[d][l] = 0;
            m_spk[d] = '0;
        end
        m_st = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.s_sum = pack(0);
        e.h_sum = pack(1);
        e.s_spk = m_spk[0];
        e.h_spk = m_spk[1];
        sb.push_back(e);
    endtask

    task automatic set_w(input int l, input int v);
        weight[l*WW +: WW] = v[WW-1:0];
    endtask

    // Applies one cycle of stimulus, advances the model, returns at posedge+1
    task automatic tick(input logic nb, input logic en, input logic sp,
                        input logic rd, input logic fm);
        int thr;
        new_block = nb; cal_en = en; input_spike = sp; read_done = rd; fire_mode = fm;
        thr = int'($signed(threshold));
        if (nb) begin
            model_clear();
        end else if (m_st == 0) begin
            if (en && sp)
                for (int d = 0; d < 2; d++)
                    for (int l = 0; l < N; l++)
                        m_sum[d][l] = sat(m_sum[d][l] + w_of(l));
            if (rd) begin
                if (fm) m_st = 1;
                else begin
                    m_st = 2;
                    m_spk[0] = '0; m_spk[1] = '0;
                    push_exp();
                end
            end
        end else if (m_st == 1) begin
            for (int d = 0; d < 2; d++)
                for (int l = 0; l < N; l++) begin
                    m_spk[d][l] = (m_sum[d][l] >= thr);
                    if (m_spk[d][l])
                        m_sum[d][l] = (d == 0) ? sat(m_sum[d][l] - thr) : 0;
                end
            m_st = 2;
            push_exp();
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every out_valid pulse must match a queued result
    always @(negedge clk) begin
        if (rstn && (if_s.out_valid || if_h.out_valid)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_valid_unexpected: soft=%b hard=%b, no result expected",
                         if_s.out_valid, if_h.out_valid);
            end else begin
                mon_e = sb.pop_front();
                if (if_s.sum !== mon_e.s_sum || if_s.out_spike !== mon_e.s_spk ||
                    if_h.sum !== mon_e.h_sum || if_h.out_spike !== mon_e.h_spk ||
                    if_s.out_valid !== 1'b1 || if_h.out_valid !== 1'b1 ||
                    if_s.cal_done !== 1'b1 || if_h.cal_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sb_result: soft sum=%h spk=%b v=%b d=%b hard sum=%h spk=%b v=%b d=%b, required soft sum=%h spk=%b hard sum=%h spk=%b",
                             if_s.sum, if_s.out_spike, if_s.out_valid, if_s.cal_done,
                             if_h.sum, if_h.out_spike, if_h.out_valid, if_h.cal_done,
                             mon_e.s_sum, mon_e.s_spk, mon_e.h_sum, mon_e.h_spk);
                end
            end
        end
    end

    task automatic test_reset();
        n_cmp++;
        if (if_s.sum !== '0 || if_h.sum !== '0) begin
            n_fail++; $display("FAIL reset_sum: soft=%h hard=%h required 0", if_s.sum, if_h.sum);
        end
        n_cmp++;
        if (if_s.cal_done !== 1'b0 || if_h.cal_done !== 1'b0 ||
            if_s.out_valid !== 1'b0 || if_h.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: done=%b/%b valid=%b/%b required 0",
                               if_s.cal_done, if_h.cal_done, if_s.out_valid, if_h.out_valid);
        end
        n_cmp++;
        if (if_s.out_spike !== '0 || if_h.out_spike !== '0) begin
            n_fail++; $display("FAIL reset_spike: soft=%b hard=%b required 0", if_s.out_spike, if_h.out_spike);
        end
    endtask

    task automatic test_sat_pos();
        int exp_v[3] = '{255, 510, 511};
        weight = '0; set_w(0, 255);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, (i == 2), 0);
            n_cmp++;
            if (lane_of(if_s.sum, 0) !== exp_v[i] || if_h.sum !== pack(1)) begin
                n_fail++; $display("FAIL sat_pos_step%0d: lane0=%0d hard=%h required %0d", i,
                                   lane_of(if_s.sum, 0), if_h.sum, exp_v[i]);
            end
        end
        n_cmp++;
        if (if_s.cal_done !== 1'b1 || if_s.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL sat_pos_done: done=%b valid=%b required 1/1", if_s.cal_done, if_s.out_valid);
        end
        tick(0, 0, 0, 0, 0);
        n_cmp++;
        if (if_s.cal_done !== 1'b1 || if_s.out_valid !== 1'b0 || lane_of(if_s.sum, 0) !== 511) begin
            n_fail++; $display("FAIL sat_pos_hold: done=%b valid=%b lane0=%0d required 1/0/511",
                               if_s.cal_done, if_s.out_valid, lane_of(if_s.sum, 0));
        end
    endtask

    task automatic test_sat_neg();
        int exp_v[3] = '{-256, -512, -512};
        weight = '0; set_w(1, -256);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, 0, 0);
            n_cmp++;
            if (lane_of(if_s.sum, 1) !== exp_v[i] || lane_of(if_h.sum, 1) !== exp_v[i]) begin
                n_fail++; $display("FAIL sat_neg_step%0d: lane1=%0d/%0d required %0d", i,
                                   lane_of(if_s.sum, 1), lane_of(if_h.sum, 1), exp_v[i]);
            end
        end
        set_w(1, 1);
        tick(0, 1, 1, 0, 0);
        n_cmp++;
        if (lane_of(if_s.sum, 1) !== -511) begin
            n_fail++; $display("FAIL sat_neg_leave: lane1=%0d required -511", lane_of(if_s.sum, 1));
        end
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_gating();
        for (int l = 0; l < N; l++) set_w(l, 5);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, (i % 2 == 1), (i % 2 == 0), 0, 0);
            n_cmp++;
            if (if_s.sum !== '0 || if_h.sum !== '0 || if_s.cal_done !== 1'b0) begin
                n_fail++; $display("FAIL gating_%0d: soft=%h hard=%h done=%b required 0",
                                   i, if_s.sum, if_h.sum, if_s.cal_done);
            end
        end
    endtask

    task automatic test_fire();
        int exp_s[N] = '{50, 99, 0, -20};
        int exp_h[N] = '{0, 99, 0, -20};
        threshold = 10'd100;
        set_w(0, 150); set_w(1, 99); set_w(2, 100); set_w(3, -20);
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 1, 1, 1);
        n_cmp++;
        if (if_s.cal_done !== 1'b0 || if_s.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL fire_t1: done=%b valid=%b required 0/0", if_s.cal_done, if_s.out_valid);
        end
        tick(0, 1, 1, 1, 1);
        n_cmp++;
        if (if_s.cal_done !== 1'b1 || if_s.out_valid !== 1'b1 ||
            if_s.out_spike !== 4'b0101 || if_h.out_spike !== 4'b0101) begin
            n_fail++; $display("FAIL fire_t2: done=%b valid=%b spk=%b/%b required 1/1/0101",
                               if_s.cal_done, if_s.out_valid, if_s.out_spike, if_h.out_spike);
        end
        for (int l = 0; l < N; l++) begin
            n_cmp++;
            if (lane_of(if_s.sum, l) !== exp_s[l] || lane_of(if_h.sum, l) !== exp_h[l]) begin
                n_fail++; $display("FAIL fire_sum_lane%0d: soft=%0d hard=%0d required %0d/%0d",
                                   l, lane_of(if_s.sum, l), lane_of(if_h.sum, l), exp_s[l], exp_h[l]);
            end
        end
        tick(0, 1, 1, 1, 1);
        n_cmp++;
        if (if_s.sum !== pack(0) || if_h.sum !== pack(1) || if_s.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL fire_done_hold: soft=%h hard=%h valid=%b required %h %h 0",
                               if_s.sum, if_h.sum, if_s.out_valid, pack(0), pack(1));
        end
        tick(1, 0, 0, 0, 0);
        n_cmp++;
        if (if_s.sum !== '0 || if_h.sum !== '0 || if_s.out_spike !== '0 ||
            if_h.out_spike !== '0 || if_s.cal_done !== 1'b0 || if_h.cal_done !== 1'b0) begin
            n_fail++; $display("FAIL fire_newblock: sum=%h/%h spk=%b/%b done=%b/%b required 0",
                               if_s.sum, if_h.sum, if_s.out_spike, if_h.out_spike, if_s.cal_done, if_h.cal_done);
        end
    endtask

    task automatic test_priority();
        weight = '0; set_w(0, 10); threshold = 10'd5;
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        tick(1, 1, 1, 1, 0);
        n_cmp++;
        if (if_s.cal_done !== 1'b0 || if_s.out_valid !== 1'b0 || if_s.sum !== '0) begin
            n_fail++; $display("FAIL prio_rd: done=%b valid=%b sum=%h required 0", if_s.cal_done, if_s.out_valid, if_s.sum);
        end
        tick(0, 1, 1, 1, 1);
        tick(1, 0, 0, 0, 0);
        n_cmp++;
        if (if_s.cal_done !== 1'b0 || if_s.out_valid !== 1'b0 || if_s.sum !== '0 ||
            if_s.out_spike !== '0 || if_h.out_spike !== '0) begin
            n_fail++; $display("FAIL prio_fire_abort: done=%b valid=%b sum=%h spk=%b required 0",
                               if_s.cal_done, if_s.out_valid, if_s.sum, if_s.out_spike);
        end
        tick(0, 0, 0, 0, 0);
        n_cmp++;
        if (if_s.cal_done !== 1'b0 || if_s.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL prio_stay_acc: done=%b valid=%b required 0", if_s.cal_done, if_s.out_valid);
        end
        tick(0, 1, 1, 1, 0);
        tick(0, 0, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (if_s.cal_done !== 1'b0 || if_s.sum !== '0 || if_h.sum !== '0 ||
            if_s.out_valid !== 1'b0 || if_s.out_spike !== '0) begin
            n_fail++; $display("FAIL async_reset: done=%b sum=%h/%h valid=%b spk=%b required 0",
                               if_s.cal_done, if_s.sum, if_h.sum, if_s.out_valid, if_s.out_spike);
        end
        model_clear();
        @(negedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_back_to_back();
        weight = '0; set_w(0, 255); threshold = -10'sd100;
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 1);
        tick(0, 0, 0, 0, 0);
        n_cmp++;
        if (lane_of(if_s.sum, 0) !== 511 || lane_of(if_h.sum, 0) !== 0 || if_s.out_spike[0] !== 1'b1) begin
            n_fail++; $display("FAIL fire_sub_sat: soft=%0d hard=%0d spk0=%b required 511/0/1",
                               lane_of(if_s.sum, 0), lane_of(if_h.sum, 0), if_s.out_spike[0]);
        end
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 1, 1, 0);
        tick(0, 1, 1, 1, 0);
        n_cmp++;
        if (if_s.out_valid !== 1'b0 || if_s.cal_done !== 1'b1 || if_s.sum !== pack(0)) begin
            n_fail++; $display("FAIL double_rd: valid=%b done=%b sum=%h required 0/1/%h",
                               if_s.out_valid, if_s.cal_done, if_s.sum, pack(0));
        end
        for (int b = 0; b < 8; b++) begin
            threshold = AW'($urandom);
            tick(1, 0, 0, 0, 0);
            for (int c = 0; c < 4 + int'($urandom_range(0, 10)); c++) begin
                weight = (N*WW)'({$urandom, $urandom});
                tick(0, 1'($urandom), 1'($urandom), 0, 0);
                n_cmp++;
                if (if_s.sum !== pack(0) || if_h.sum !== pack(1)) begin
                    n_fail++; $display("FAIL rand_acc_b%0d: soft=%h hard=%h required %h %h",
                                       b, if_s.sum, if_h.sum, pack(0), pack(1));
                end
            end
            tick(0, 1, 1, 1, (b % 2 == 0));
            tick(0, 0, 0, 0, 0);
            tick(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        rstn = 1'b0;
        new_block = 0; cal_en = 0; input_spike = 0; read_done = 0; fire_mode = 0;
        threshold = '0; weight = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        test_sat_pos();
        test_sat_neg();
        test_gating();
        test_fire();
        test_priority();
        test_back_to_back();
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: %0d results never produced, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdfa_neuron_array.md
# sdfa_neuron_array

Parametrised array of N_NEURON signed accumulate neurons sharing one input-spike stream, each with its own weight lane. It generalises the single-neuron adder: configurable weight and accumulator widths, saturating arithmetic at any width, and an optional integrate-and-fire phase that compares each sum against a threshold, emits output spikes and applies a soft or hard reset. It sits between the spike/weight fetch stage and the layer output buffer. It signals completion of each block with `cal_done` and a one-cycle `out_valid` pulse.

## Interface
- N_NEURON, 8, number of neuron lanes (>=1)
- W_WIDTH, 9, signed two's-complement weight width per lane
- ACC_WIDTH, 10, signed accumulator width; ACC_WIDTH >= W_WIDTH
- HARD_RESET, 0, 0: fired neuron does sum-=threshold; 1: fired neuron does sum=0
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- new_block  in  1  start of new block; clears all lanes and state
- cal_en  in  1  accumulation enable
- input_spike  in  1  shared input spike for the current cycle
- read_done  in  1  marks the last accumulation cycle of the block
- fire_mode  in  1  1: run FIRE phase after accumulation; sampled on the read_done cycle
- threshold  in  ACC_WIDTH  signed firing threshold; sampled in FIRE
- weight  in  N_NEURON*W_WIDTH  lane i at [i*W_WIDTH +: W_WIDTH]
- cal_done  out  1  block finished; sums and spikes stable
- out_valid  out  1  one-cycle pulse on the cal_done rising cycle
- out_spike  out  N_NEURON  per-lane fire result, valid while cal_done=1
- sum  out  N_NEURON*ACC_WIDTH  lane i at [i*ACC_WIDTH +: ACC_WIDTH]

## Operation
- FSM states are ACC, FIRE and DONE. The reset state is ACC.
- Reset (rstn=0): state=ACC, all sums=0, cal_done=0, out_valid=0, out_spike=0.
- new_block has the highest priority in any state. Next cycle: state=ACC, sums=0, out_spike=0, cal_done=0, out_valid=0. Accumulation is suppressed in that cycle.
- ACC: each cycle with cal_en=1 and input_spike=1, every lane does sum_i <= sat(sum_i + sext(w_i)). Otherwise the sum holds.
- sext: sign-extend W_WIDTH to ACC_WIDTH.
- sat: positive overflow (both operands >=0, result <0) clamps to MAX = 2^(ACC_WIDTH-1)-1. Negative overflow clamps to MIN = -2^(ACC_WIDTH-1).
- ACC with read_done=1: the accumulation for that cycle is still applied.
  - fire_mode=1 -> FIRE.
  - fire_mode=0 -> DONE, with cal_done<=1, out_valid<=1 and out_spike=0.
- FIRE (exactly one cycle): out_spike_i <= (signed sum_i >= signed threshold). Fired lanes get sum_i <= 0 if HARD_RESET, else sat(sum_i - threshold). Non-fired lanes hold. Then -> DONE with cal_done<=1, out_valid<=1. Inputs cal_en, input_spike and read_done are ignored.
- DONE: all outputs hold and all inputs except new_block are ignored. out_valid is high for the first DONE cycle only.
- Lanes are independent. There is no cross-lane arithmetic.

## Timing
- All outputs are registered. There is no combinational input->output path.
- With read_done at cycle t:
  - fire_mode=0: cal_done and out_valid are high from t+1.
  - fire_mode=1: cal_done and out_valid are high from t+2; out_spike and post-reset sums are visible at t+2.
- new_block together with read_done in the same cycle: new_block wins, and the block restarts in ACC.
- new_block during FIRE: FIRE is aborted and no spikes are emitted.
- A read_done on consecutive cycles in ACC is equivalent to one read_done.
- Reset asserted mid-block returns every output to its reset value immediately (asynchronously).
- Saturation holds at the bound: further same-sign adds keep the sum at MAX or MIN. An opposite-sign add leaves the bound normally.

## Test plan
- Non-fire saturation (N=4, W=9, ACC=10), lane0 w=255: spikes at cycles 1, 2, 3, with read_done on cycle 3 -> sum0 = 255, 510, 511. cal_done and out_valid high on the next cycle; out_valid is low the cycle after.
- Negative saturation, lane1 w=-256: three spikes -> sum1 = -256, -512, -512. Then lane1 w=+1 with one spike -> -511.
- Gating: cal_en=0 with input_spike=1, or cal_en=1 with input_spike=0, for 5 cycles -> all sums stay 0.
- Fire soft reset: threshold=100, lane sums {150, 99, 100, -20}, read_done with fire_mode=1 -> out_spike=4'b0101, sums {50, 99, 0, -20}, cal_done at t+2.
- Fire hard reset (HARD_RESET=1), same stimulus -> sums {0, 99, 0, -20}. Then new_block -> sums 0, out_spike 0, cal_done 0 the next cycle.
- Priority: new_block asserted with read_done, and again in the FIRE cycle -> no cal_done, no out_valid, sums cleared. An async rstn pulse in DONE clears all outputs immediately.
